// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arb_pkg : arbitration state and grant-select encodings for          |
// |                dmem_arbiter.                                             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_CORE  = 2'd0,
    ARB_FORCE = 2'd1,
    ARB_LOCK  = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CORE = 2'd1;
  localparam logic [1:0] GNT_EXT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter : shares single-port dmem between core M-stage and an       |
// |                external requester; optional stats via DMEM_ARB_STATS_EN. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_adr,
  input  logic [DW-1:0] core_wd,
  output logic [DW-1:0] core_rd,
  output logic          core_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic          ext_lock,
  input  logic [AW-1:0] ext_adr,
  input  logic [DW-1:0] ext_wd,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rd,
  output logic          ext_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_stall,
  output logic [31:0]   stat_ext
`endif
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam logic [SCW-1:0] c_STARVE_LIM = SCW'(STARVE_MAX);
  localparam logic [LCW-1:0] c_LOCK_LIM   = LCW'(LOCK_MAX);

  arb_state_t     r_state, w_state_nxt;
  logic [SCW-1:0] r_starve, w_starve_nxt, w_starve_inc;
  logic [LCW-1:0] r_lock, w_lock_nxt;
  logic [1:0]     w_gnt;
  logic           w_lock_cont;
  logic           r_ext_rvalid;
  logic [DW-1:0]  r_ext_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ARB_CORE;
      r_starve <= '0;
      r_lock   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_lock   <= w_lock_nxt;
    end
  end

  assign w_starve_inc = (r_starve == c_STARVE_LIM) ? r_starve : r_starve + SCW'(1);
  assign w_lock_cont  = (r_state == ARB_LOCK) && ext_req && ext_lock && (r_lock != c_LOCK_LIM);

  always_comb begin
    w_gnt        = GNT_NONE;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_lock_nxt   = r_lock;
    if (!reset) begin
      w_gnt = GNT_NONE;
    end else if (r_state == ARB_FORCE) begin
      w_gnt        = GNT_EXT;
      w_starve_nxt = '0;
      if (ext_lock) begin
        w_state_nxt = ARB_LOCK;
        w_lock_nxt  = LCW'(1);
      end else begin
        w_state_nxt = ARB_CORE;
      end
    end else if (w_lock_cont) begin
      w_gnt      = GNT_EXT;
      w_lock_nxt = r_lock + LCW'(1);
    end else begin
      // Normal arbitration; also the cycle in which a locked burst is released.
      w_state_nxt = ARB_CORE;
      if (r_state == ARB_LOCK) w_starve_nxt = '0;
      if (core_req) begin
        w_gnt = GNT_CORE;
        if (ext_req && (r_state != ARB_LOCK)) begin
          w_starve_nxt = w_starve_inc;
          if (w_starve_inc == c_STARVE_LIM) w_state_nxt = ARB_FORCE;
        end
      end else if (ext_req) begin
        w_gnt        = GNT_EXT;
        w_starve_nxt = '0;
        if (ext_lock) begin
          w_state_nxt = ARB_LOCK;
          w_lock_nxt  = LCW'(1);
        end
      end
    end
  end

  always_comb begin
    mem_we = 1'b0;
    case (w_gnt)
      GNT_CORE: mem_we = core_we;
      GNT_EXT:  mem_we = ext_we;
      default:  mem_we = 1'b0;
    endcase
  end

  assign mem_adr    = (w_gnt == GNT_EXT) ? ext_adr : core_adr;
  assign mem_wd     = (w_gnt == GNT_EXT) ? ext_wd  : core_wd;
  assign ext_gnt    = (w_gnt == GNT_EXT);
  assign core_stall = reset && core_req && (w_gnt != GNT_CORE);
  assign core_rd    = mem_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext_rvalid <= 1'b0;
      r_ext_rd     <= '0;
    end else begin
      r_ext_rvalid <= ext_gnt && !ext_we;
      if (ext_gnt && !ext_we) r_ext_rd <= mem_rd;
    end
  end

  assign ext_rvalid = r_ext_rvalid;
  assign ext_rd     = r_ext_rd;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_stall, r_stat_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_stall <= '0;
      r_stat_ext   <= '0;
    end else begin
      if (core_stall && (r_stat_stall != 32'hFFFF_FFFF)) r_stat_stall <= r_stat_stall + 32'd1;
      if (ext_gnt && (r_stat_ext != 32'hFFFF_FFFF))      r_stat_ext   <= r_stat_ext + 32'd1;
    end
  end

  assign stat_stall = r_stat_stall;
  assign stat_ext   = r_stat_ext;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed scenarios plus randomized traffic checked     |
// |                   against an ownership-rule reference model.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int AW = 32, DW = 32, STARVE_MAX = 4, LOCK_MAX = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, core_stall;
  logic [AW-1:0] core_adr;
  logic [DW-1:0] core_wd, core_rd;
  logic          ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
  logic [AW-1:0] ext_adr;
  logic [DW-1:0] ext_wd, ext_rd;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   stat_stall, stat_ext;
`endif

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rd = dmem[mem_adr[7:0]];
  always @(posedge clk) if (mem_we) dmem[mem_adr[7:0]] <= mem_wd;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wd(core_wd),
    .core_rd(core_rd), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_adr(ext_adr),
    .ext_wd(ext_wd), .ext_gnt(ext_gnt), .ext_rd(ext_rd), .ext_rvalid(ext_rvalid),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .stat_stall(stat_stall), .stat_ext(stat_ext)
`endif
  );

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_adr = '0; core_wd = '0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_adr = '0; ext_wd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    core_req = 1; ext_req = 1; ext_we = 1;
    @(negedge clk);
    n_checks++;
    if (ext_gnt !== 1'b0 || core_stall !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb: gnt=%b stall=%b we=%b, want 0 0 0", ext_gnt, core_stall, mem_we);
    end
    n_checks++;
    if (ext_rvalid !== 1'b0 || ext_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_regs: rvalid=%b rd=%h, want 0 00000000", ext_rvalid, ext_rd);
    end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_core_store();
    @(posedge clk); #1;
    core_req = 1; core_we = 1; core_adr = 32'h40; core_wd = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || mem_adr !== 32'h40 || mem_wd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL core_store_bus: we=%b adr=%h wd=%h, want 1 00000040 deadbeef", mem_we, mem_adr, mem_wd);
    end
    n_checks++;
    if (core_stall !== 1'b0 || ext_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL core_store_stall: stall=%b gnt=%b, want 0 0", core_stall, ext_gnt);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (dmem[8'h40] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL core_store_mem: dmem[40]=%h, want deadbeef", dmem[8'h40]);
    end
  endtask

  task automatic test_ext_read();
    @(posedge clk); #1;
    core_req = 1; core_we = 1; core_adr = 32'h80; core_wd = 32'h1234;
    @(posedge clk); #1;
    idle_inputs();
    ext_req = 1; ext_adr = 32'h80;
    @(negedge clk);
    n_checks++;
    if (ext_gnt !== 1'b1 || ext_rvalid !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_read_gnt: gnt=%b rvalid=%b we=%b, want 1 0 0", ext_gnt, ext_rvalid, mem_we);
    end
    @(posedge clk); #1;
    ext_req = 0;
    @(negedge clk);
    n_checks++;
    if (ext_rvalid !== 1'b1 || ext_rd !== 32'h1234 || ext_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_read_data: rvalid=%b rd=%h gnt=%b, want 1 00001234 0", ext_rvalid, ext_rd, ext_gnt);
    end
    @(negedge clk);
    n_checks++;
    if (ext_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_read_pulse: rvalid=%b, want 0", ext_rvalid);
    end
  endtask

  task automatic test_starve();
    logic exp;
    do_reset();
    @(posedge clk); #1;
    core_req = 1; core_adr = 32'h10; ext_req = 1; ext_adr = 32'h20;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp = (c == 5);
      n_checks++;
      if (ext_gnt !== exp || core_stall !== exp || mem_adr !== (exp ? 32'h20 : 32'h10)) begin
        n_fail++;
        $display("FAIL starve_c%0d: gnt=%b stall=%b adr=%h, want %b %b %h", c, ext_gnt, core_stall,
                 mem_adr, exp, exp, exp ? 32'h20 : 32'h10);
      end
      @(posedge clk); #1;
      if (c == 5) ext_req = 0;
    end
    @(negedge clk);
    n_checks++;
    if (ext_gnt !== 1'b0 || core_stall !== 1'b0 || ext_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_resume: gnt=%b stall=%b rvalid=%b, want 0 0 1", ext_gnt, core_stall, ext_rvalid);
    end
`ifdef DMEM_ARB_STATS_EN
    n_checks++;
    if (stat_stall !== 32'd1 || stat_ext !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_starve: stall=%0d ext=%0d, want 1 1", stat_stall, stat_ext);
    end
`endif
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    int  grants;
    logic exp, g;
    do_reset();
    @(posedge clk); #1;
    core_req = 1; core_adr = 32'h10;
    ext_req = 1; ext_lock = 1; ext_adr = 32'h20;
    grants = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      exp = (c >= 5 && c <= 12);
      g = ext_gnt;
      n_checks++;
      if (ext_gnt !== exp || core_stall !== exp) begin
        n_fail++;
        $display("FAIL lock_c%0d: gnt=%b stall=%b, want %b %b", c, ext_gnt, core_stall, exp, exp);
      end
      n_checks++;
      if (ext_rvalid !== (c >= 6 && c <= 13)) begin
        n_fail++;
        $display("FAIL lock_rvalid_c%0d: rvalid=%b, want %b", c, ext_rvalid, (c >= 6 && c <= 13));
      end
      if (g) grants++;
      @(posedge clk); #1;
      if (g) ext_adr = ext_adr + 32'd4;
      ext_req = (grants < 12);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    @(posedge clk); #1;
    ext_req = 1; ext_lock = 1; ext_adr = 32'h30;
    @(negedge clk);
    n_checks++;
    if (ext_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midlock_first: gnt=%b, want 1", ext_gnt);
    end
    @(posedge clk); #1;
    ext_we = 1; ext_adr = 32'h34; ext_wd = 32'hA5A5_0001;
    @(negedge clk);
    n_checks++;
    if (ext_gnt !== 1'b1 || mem_we !== 1'b1 || ext_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL midlock_burst: gnt=%b we=%b rvalid=%b, want 1 1 1", ext_gnt, mem_we, ext_rvalid);
    end
    #1;
    reset = 1'b0;
    core_req = 1; core_adr = 32'h10;
    #1;
    n_checks++;
    if (ext_gnt !== 1'b0 || mem_we !== 1'b0 || ext_rvalid !== 1'b0 || core_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL midlock_reset: gnt=%b we=%b rvalid=%b stall=%b, want 0 0 0 0", ext_gnt, mem_we,
               ext_rvalid, core_stall);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (core_stall !== 1'b0 || ext_gnt !== 1'b0 || mem_adr !== 32'h10) begin
      n_fail++;
      $display("FAIL midlock_release: stall=%b gnt=%b adr=%h, want 0 0 00000010", core_stall, ext_gnt, mem_adr);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Reference model: ownership rules tracked as a denied-run count, a pending
  // forced grant, and the length of the current locked burst.
  task automatic test_random();
    int   m_run, m_blen, g;
    bit   m_force, m_burst, cont, core_hold, ext_hold, lock_again;
    bit   e_gnt, e_stall, e_we, e_rv;
    logic [31:0] e_adr, e_wd, e_rd;
    int   m_stall_cnt, m_ext_cnt;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) ref_mem[i] = dmem[i];
    m_run = 0; m_blen = 0; m_force = 0; m_burst = 0; e_rv = 0; e_rd = '0;
    core_hold = 0; ext_hold = 0; lock_again = 0; m_stall_cnt = 0; m_ext_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (!core_hold) begin
        core_req = ($urandom_range(0, 3) != 0);
        core_we  = $urandom_range(0, 1);
        core_adr = 32'($urandom_range(0, 63));
        core_wd  = $urandom;
      end
      if (!ext_hold) begin
        if (lock_again && $urandom_range(0, 7) != 0) begin
          ext_req = 1; ext_lock = 1;
        end else begin
          ext_req  = ($urandom_range(0, 2) != 0);
          ext_lock = ($urandom_range(0, 2) == 0);
        end
        ext_we  = $urandom_range(0, 1);
        ext_adr = 32'($urandom_range(0, 63));
        ext_wd  = $urandom;
      end
      cont = 0;
      if (m_force) g = 2;
      else if (m_burst && ext_req && ext_lock && m_blen < LOCK_MAX) begin g = 2; cont = 1; end
      else g = core_req ? 1 : (ext_req ? 2 : 0);
      e_gnt   = (g == 2);
      e_stall = core_req && (g != 1);
      e_we    = (g == 1) ? core_we : ((g == 2) ? ext_we : 1'b0);
      e_adr   = (g == 2) ? ext_adr : core_adr;
      e_wd    = (g == 2) ? ext_wd : core_wd;
      @(negedge clk);
      n_checks++;
      if (ext_gnt !== e_gnt || core_stall !== e_stall || mem_we !== e_we || mem_adr !== e_adr ||
          (e_we && mem_wd !== e_wd)) begin
        n_fail++;
        $display("FAIL rand_c%0d_bus: gnt=%b stall=%b we=%b adr=%h wd=%h, want %b %b %b %h %h", c, ext_gnt,
                 core_stall, mem_we, mem_adr, mem_wd, e_gnt, e_stall, e_we, e_adr, e_wd);
      end
      n_checks++;
      if (ext_rvalid !== e_rv || (e_rv && ext_rd !== e_rd)) begin
        n_fail++;
        $display("FAIL rand_c%0d_rd: rvalid=%b rd=%h, want %b %h", c, ext_rvalid, ext_rd, e_rv, e_rd);
      end
      if (g == 1 && !core_we) begin
        n_checks++;
        if (core_rd !== ref_mem[core_adr[7:0]]) begin
          n_fail++;
          $display("FAIL rand_c%0d_core_rd: rd=%h, want %h", c, core_rd, ref_mem[core_adr[7:0]]);
        end
      end
      e_rv = e_gnt && !ext_we;
      if (e_rv) e_rd = ref_mem[ext_adr[7:0]];
      if (g == 1 && core_we) ref_mem[core_adr[7:0]] = core_wd;
      if (g == 2 && ext_we)  ref_mem[ext_adr[7:0]]  = ext_wd;
      m_stall_cnt += int'(e_stall);
      m_ext_cnt   += int'(e_gnt);
      if (cont) m_blen++;
      else if (g == 2) begin
        m_force = 0; m_run = 0; m_burst = ext_lock; m_blen = 1;
      end else if (m_burst) begin
        m_burst = 0; m_run = 0;
      end else if (ext_req) begin
        m_run++;
        if (m_run == STARVE_MAX) m_force = 1;
      end
      core_hold  = e_stall;
      ext_hold   = ext_req && !e_gnt;
      lock_again = e_gnt && ext_lock;
      @(posedge clk); #1;
    end
    idle_inputs();
`ifdef DMEM_ARB_STATS_EN
    n_checks++;
    if (stat_stall !== 32'(m_stall_cnt) || stat_ext !== 32'(m_ext_cnt)) begin
      n_fail++;
      $display("FAIL rand_stats: stall=%0d ext=%0d, want %0d %0d", stat_stall, stat_ext, m_stall_cnt, m_ext_cnt);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_core_store();
    test_ext_read();
    test_starve();
    test_lock_burst();
    test_reset_mid_lock();
    test_random();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
